// File: rtl/n1_sagu.sv
// Stack address generation unit: arbitrates PS/RS push/pull requests, runs the
// matching pipelined Wishbone access on the shared stack RAM and steers the DSP pointers.
module n1_sagu #(
    parameter int unsigned SP_WIDTH = 12
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,

    input  logic                ps_push_req_i,
    input  logic                ps_pull_req_i,
    input  logic [15:0]         ps_push_data_i,
    output logic                ps_ack_o,
    output logic                ps_err_o,
    output logic [15:0]         ps_pull_data_o,

    input  logic                rs_push_req_i,
    input  logic                rs_pull_req_i,
    input  logic [15:0]         rs_push_data_i,
    output logic                rs_ack_o,
    output logic                rs_err_o,
    output logic [15:0]         rs_pull_data_o,

    input  logic                fc2sagu_ps_rst_i,
    input  logic                fc2sagu_rs_rst_i,

    input  logic [SP_WIDTH-1:0] dsp2sagu_psp_next_i,
    input  logic [SP_WIDTH-1:0] dsp2sagu_rsp_next_i,

    output logic                sagu2dsp_psp_hold_o,
    output logic                sagu2dsp_psp_op_sel_o,
    output logic [SP_WIDTH-1:0] sagu2dsp_psp_offs_o,
    output logic [SP_WIDTH-1:0] sagu2dsp_psp_load_val_o,
    output logic                sagu2dsp_rsp_hold_o,
    output logic                sagu2dsp_rsp_op_sel_o,
    output logic [SP_WIDTH-1:0] sagu2dsp_rsp_offs_o,
    output logic [SP_WIDTH-1:0] sagu2dsp_rsp_load_val_o,

    output logic                sbus_cyc_o,
    output logic                sbus_stb_o,
    output logic                sbus_we_o,
    output logic [SP_WIDTH-1:0] sbus_adr_o,
    output logic [15:0]         sbus_dat_o,
    input  logic                sbus_ack_i,
    input  logic                sbus_stall_i,
    input  logic [15:0]         sbus_dat_i
);

    localparam int unsigned SPW1 = SP_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ADR, WAIT, ACK} state_t;

    state_t                state_q, state_d;
    logic                  rs_sel_q, rs_sel_d;
    logic                  push_q, push_d;
    logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [SP_WIDTH-1:0]   adr_q, adr_d;
    logic [15:0]           dat_q, dat_d;
    logic                  ps_ack_q, ps_ack_d, ps_err_q, ps_err_d;
    logic                  rs_ack_q, rs_ack_d, rs_err_q, rs_err_d;
    logic [15:0]           ps_pull_q, ps_pull_d, rs_pull_q, rs_pull_d;

    logic                  full_c, ps_empty_c, rs_empty_c, bus_done_c;

    assign full_c     = (SPW1'(dsp2sagu_rsp_next_i) + SPW1'(1)) == SPW1'(dsp2sagu_psp_next_i);
    assign ps_empty_c = dsp2sagu_psp_next_i == '0;
    assign rs_empty_c = dsp2sagu_rsp_next_i == '1;
    assign bus_done_c = ((state_q == ADR) || (state_q == WAIT)) && sbus_ack_i;

    // Next-state, bus setup and combinational DSP pointer control
    always_comb begin
        state_d   = state_q;
        rs_sel_d  = rs_sel_q;
        push_d    = push_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        ps_ack_d  = 1'b0;
        ps_err_d  = 1'b0;
        rs_ack_d  = 1'b0;
        rs_err_d  = 1'b0;
        ps_pull_d = ps_pull_q;
        rs_pull_d = rs_pull_q;

        sagu2dsp_psp_hold_o     = 1'b1;
        sagu2dsp_psp_op_sel_o   = 1'b0;
        sagu2dsp_psp_offs_o     = '0;
        sagu2dsp_psp_load_val_o = '0;
        sagu2dsp_rsp_hold_o     = 1'b1;
        sagu2dsp_rsp_op_sel_o   = 1'b0;
        sagu2dsp_rsp_offs_o     = '0;
        sagu2dsp_rsp_load_val_o = '0;

        case (state_q)
            IDLE: begin
                if (fc2sagu_ps_rst_i || fc2sagu_rs_rst_i) begin
                    if (fc2sagu_ps_rst_i) begin
                        sagu2dsp_psp_hold_o     = 1'b0;
                        sagu2dsp_psp_op_sel_o   = 1'b1;
                        sagu2dsp_psp_load_val_o = '0;
                    end
                    if (fc2sagu_rs_rst_i) begin
                        sagu2dsp_rsp_hold_o     = 1'b0;
                        sagu2dsp_rsp_op_sel_o   = 1'b1;
                        sagu2dsp_rsp_load_val_o = '1;
                    end
                end else if (rs_push_req_i || rs_pull_req_i) begin
                    rs_sel_d = 1'b1;
                    push_d   = rs_push_req_i;
                    if (rs_push_req_i ? full_c : rs_empty_c) begin
                        state_d  = ACK;
                        rs_ack_d = 1'b1;
                        rs_err_d = 1'b1;
                    end else begin
                        state_d = ADR;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = rs_push_req_i;
                        adr_d   = rs_push_req_i ? dsp2sagu_rsp_next_i
                                                : dsp2sagu_rsp_next_i + SP_WIDTH'(1);
                        if (rs_push_req_i) dat_d = rs_push_data_i;
                    end
                end else if (ps_push_req_i || ps_pull_req_i) begin
                    rs_sel_d = 1'b0;
                    push_d   = ps_push_req_i;
                    if (ps_push_req_i ? full_c : ps_empty_c) begin
                        state_d  = ACK;
                        ps_ack_d = 1'b1;
                        ps_err_d = 1'b1;
                    end else begin
                        state_d = ADR;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = ps_push_req_i;
                        adr_d   = ps_push_req_i ? dsp2sagu_psp_next_i
                                                : dsp2sagu_psp_next_i - SP_WIDTH'(1);
                        if (ps_push_req_i) dat_d = ps_push_data_i;
                    end
                end
            end
            ADR: begin
                if (!sbus_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: ;
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus acknowledge completes the access regardless of the stall phase
        if (bus_done_c) begin
            state_d = ACK;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            if (rs_sel_q) begin
                rs_ack_d            = 1'b1;
                sagu2dsp_rsp_hold_o = 1'b0;
                sagu2dsp_rsp_offs_o = push_q ? '1 : SP_WIDTH'(1);
                if (!push_q) rs_pull_d = sbus_dat_i;
            end else begin
                ps_ack_d            = 1'b1;
                sagu2dsp_psp_hold_o = 1'b0;
                sagu2dsp_psp_offs_o = push_q ? SP_WIDTH'(1) : '1;
                if (!push_q) ps_pull_d = sbus_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q   <= IDLE;
            rs_sel_q  <= 1'b0;
            push_q    <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            ps_ack_q  <= 1'b0;
            ps_err_q  <= 1'b0;
            rs_ack_q  <= 1'b0;
            rs_err_q  <= 1'b0;
            ps_pull_q <= '0;
            rs_pull_q <= '0;
        end else begin
            state_q   <= state_d;
            rs_sel_q  <= rs_sel_d;
            push_q    <= push_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            ps_ack_q  <= ps_ack_d;
            ps_err_q  <= ps_err_d;
            rs_ack_q  <= rs_ack_d;
            rs_err_q  <= rs_err_d;
            ps_pull_q <= ps_pull_d;
            rs_pull_q <= rs_pull_d;
        end
    end

    assign sbus_cyc_o     = cyc_q;
    assign sbus_stb_o     = stb_q;
    assign sbus_we_o      = we_q;
    assign sbus_adr_o     = adr_q;
    assign sbus_dat_o     = dat_q;
    assign ps_ack_o       = ps_ack_q;
    assign ps_err_o       = ps_err_q;
    assign rs_ack_o       = rs_ack_q;
    assign rs_err_o       = rs_err_q;
    assign ps_pull_data_o = ps_pull_q;
    assign rs_pull_data_o = rs_pull_q;

endmodule

// File: tb/tb_n1_sagu.sv
// Directed bench for n1_sagu at SP_WIDTH=4; the bench plays the stack bus slave by hand.
module tb_n1_sagu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_push, ps_pull, rs_push, rs_pull;
    logic [15:0] ps_pdata, rs_pdata;
    logic        ps_ack, ps_err, rs_ack, rs_err;
    logic [15:0] ps_rdata, rs_rdata;
    logic        fc_ps, fc_rs;
    logic [3:0]  psp, rsp;
    logic        psp_hold, psp_op, rsp_hold, rsp_op;
    logic [3:0]  psp_offs, psp_load, rsp_offs, rsp_load;
    logic        cyc, stb, we;
    logic [3:0]  adr;
    logic [15:0] dato, sdati;
    logic        sack, sstall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    n1_sagu #(.SP_WIDTH(4)) dut (
        .clk_i(clk), .sync_rst_i(rst),
        .ps_push_req_i(ps_push), .ps_pull_req_i(ps_pull), .ps_push_data_i(ps_pdata),
        .ps_ack_o(ps_ack), .ps_err_o(ps_err), .ps_pull_data_o(ps_rdata),
        .rs_push_req_i(rs_push), .rs_pull_req_i(rs_pull), .rs_push_data_i(rs_pdata),
        .rs_ack_o(rs_ack), .rs_err_o(rs_err), .rs_pull_data_o(rs_rdata),
        .fc2sagu_ps_rst_i(fc_ps), .fc2sagu_rs_rst_i(fc_rs),
        .dsp2sagu_psp_next_i(psp), .dsp2sagu_rsp_next_i(rsp),
        .sagu2dsp_psp_hold_o(psp_hold), .sagu2dsp_psp_op_sel_o(psp_op),
        .sagu2dsp_psp_offs_o(psp_offs), .sagu2dsp_psp_load_val_o(psp_load),
        .sagu2dsp_rsp_hold_o(rsp_hold), .sagu2dsp_rsp_op_sel_o(rsp_op),
        .sagu2dsp_rsp_offs_o(rsp_offs), .sagu2dsp_rsp_load_val_o(rsp_load),
        .sbus_cyc_o(cyc), .sbus_stb_o(stb), .sbus_we_o(we),
        .sbus_adr_o(adr), .sbus_dat_o(dato),
        .sbus_ack_i(sack), .sbus_stall_i(sstall), .sbus_dat_i(sdati)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ps_push = 0; ps_pull = 0; rs_push = 0; rs_pull = 0;
        ps_pdata = '0; rs_pdata = '0; fc_ps = 0; fc_rs = 0;
        psp = 4'h0; rsp = 4'hF; sack = 0; sstall = 0; sdati = '0;
        tick(); tick();

        chk("rst_cyc", 32'(cyc), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_adr", 32'(adr), 0);
        chk("rst_dat", 32'(dato), 0);
        chk("rst_acks", 32'({ps_ack, ps_err, rs_ack, rs_err}), 0);
        chk("rst_holds", 32'({psp_hold, rsp_hold}), 3);
        chk("rst_pull", 32'(ps_rdata), 0);
        rst = 1'b0;

        // PS push of 0xBEEF at PSP=0
        ps_push = 1; ps_pdata = 16'hBEEF; #1;
        chk("push_idle_hold", 32'(psp_hold), 1);
        tick();
        chk("push_adr_cyc", 32'({cyc, stb, we}), 7);
        chk("push_adr", 32'(adr), 0);
        chk("push_dat", 32'(dato), 32'hBEEF);
        chk("push_noack", 32'(ps_ack), 0);
        tick();
        chk("push_wait", 32'({cyc, stb}), 2);
        sack = 1; #1;
        chk("push_upd", 32'({psp_hold, psp_op, psp_offs}), 32'h01);
        tick();
        sack = 0; ps_push = 0; psp = 4'h1; #1;
        chk("push_ack", 32'({ps_ack, ps_err, cyc}), 4);
        chk("push_hold_after", 32'(psp_hold), 1);
        tick();
        chk("push_ack_drop", 32'(ps_ack), 0);

        // PS pull at PSP=1, slave returns 0x1234
        ps_pull = 1; tick();
        chk("pull_adr", 32'(adr), 0);
        chk("pull_we", 32'({stb, we}), 2);
        tick();
        sack = 1; sdati = 16'h1234; #1;
        chk("pull_upd", 32'({psp_hold, psp_offs}), 32'h0F);
        tick();
        sack = 0; ps_pull = 0; psp = 4'h0; #1;
        chk("pull_ack", 32'({ps_ack, ps_err}), 2);
        chk("pull_data", 32'(ps_rdata), 32'h1234);
        tick();

        // RS and PS push together at PSP=5, RSP=6: RS wins
        psp = 4'h5; rsp = 4'h6;
        rs_push = 1; rs_pdata = 16'hCAFE; ps_push = 1; ps_pdata = 16'h1111;
        tick();
        chk("col_rs_adr", 32'(adr), 6);
        chk("col_rs_dat", 32'(dato), 32'hCAFE);
        tick();
        sack = 1; #1;
        chk("col_rs_upd", 32'({rsp_hold, rsp_offs, psp_hold}), 32'h1F);
        tick();
        sack = 0; rs_push = 0; rsp = 4'h5; #1;
        chk("col_rs_ack", 32'({rs_ack, ps_ack}), 2);
        tick();
        chk("col_idle", 32'(cyc), 0);
        // PSP=5, RSP=5 leaves one free cell, so the held PS push is served
        tick();
        chk("col_ps_adr", 32'(adr), 5);
        chk("col_ps_dat", 32'(dato), 32'h1111);
        tick();
        sack = 1; tick();
        sack = 0; ps_push = 0; psp = 4'h6; #1;
        chk("col_ps_ack", 32'({ps_ack, ps_err}), 2);
        tick();

        // PSP=6, RSP=5: full, push errors without a bus cycle
        ps_push = 1; #1;
        chk("full_hold", 32'(psp_hold), 1);
        tick();
        chk("full_err", 32'({ps_ack, ps_err, cyc}), 6);
        ps_push = 0; tick();
        chk("full_ack_drop", 32'(ps_ack), 0);

        // RS pull from empty RS
        psp = 4'h0; rsp = 4'hF; rs_pull = 1; #1;
        chk("uf_hold", 32'(rsp_hold), 1);
        tick();
        chk("uf_err", 32'({rs_ack, rs_err, cyc}), 6);
        rs_pull = 0; tick();

        // Stall held for three sampled cycles
        psp = 4'h2; sstall = 1; ps_push = 1; ps_pdata = 16'h5A5A;
        tick();
        chk("st_stb1", 32'({stb, adr}), 32'h12);
        tick();
        chk("st_stb2", 32'({stb, dato}), 32'h15A5A);
        tick();
        chk("st_stb3", 32'({stb, adr}), 32'h12);
        tick();
        sstall = 0; #1;
        chk("st_stb4", 32'({stb, adr}), 32'h12);
        chk("st_nohold", 32'(psp_hold), 1);
        tick();
        chk("st_wait", 32'({cyc, stb}), 2);
        sack = 1; #1;
        chk("st_upd", 32'({psp_hold, psp_offs}), 32'h01);
        tick();
        sack = 0; ps_push = 0; psp = 4'h3; #1;
        chk("st_ack", 32'({ps_ack, psp_hold}), 3);
        tick();

        // Synchronous reset while waiting for the slave
        ps_pull = 1; tick(); tick();
        chk("rw_wait", 32'({cyc, stb}), 2);
        rst = 1; tick();
        chk("rw_cyc", 32'(cyc), 0);
        chk("rw_noack", 32'(ps_ack), 0);
        chk("rw_holds", 32'({psp_hold, rsp_hold}), 3);
        chk("rw_pull_clr", 32'(ps_rdata), 0);
        rst = 0; ps_pull = 0; tick();
        chk("rw_idle", 32'({cyc, ps_ack}), 0);

        // PS reset command beats a simultaneous RS push
        rsp = 4'hF; fc_ps = 1; rs_push = 1; rs_pdata = 16'h7777; #1;
        chk("fc_psp", 32'({psp_op, psp_hold, psp_load}), 32'h20);
        chk("fc_rsp_idle", 32'(rsp_hold), 1);
        tick();
        fc_ps = 0; #1;
        chk("fc_no_bus", 32'(cyc), 0);
        chk("fc_psp_back", 32'({psp_op, psp_hold}), 1);
        tick();
        chk("fc_rs_adr", 32'({cyc, adr}), 32'h1F);
        chk("fc_rs_dat", 32'(dato), 32'h7777);
        tick();
        sack = 1; tick();
        sack = 0; rs_push = 0; rsp = 4'hE; #1;
        chk("fc_rs_ack", 32'({rs_ack, rs_err}), 2);
        tick();

        // RS reset command loads all-ones
        fc_rs = 1; #1;
        chk("fcr_rsp", 32'({rsp_op, rsp_hold, rsp_load}), 32'h2F);
        tick();
        fc_rs = 0; #1;
        chk("fcr_back", 32'({rsp_op, rsp_hold, rs_ack}), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
